// File: rtl/down_counter_pkg.sv
// Shared constants and state encoding for the down counter.
package down_counter_pkg;

    localparam int DC_WIDTH = 7;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_t;

endpackage

// File: rtl/down_counter.sv
// Loadable, pausable down counter with one-cycle terminal-count pulse.
// One-shot or auto-reload operation; abort > start > decrement > hold.
module down_counter
    import down_counter_pkg::*;
#(
    parameter int WIDTH = DC_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             en,
    input  logic             auto_rel,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] rel_q, rel_d;
    logic             tc_q, tc_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            rel_q   <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            rel_q   <= rel_d;
            tc_q    <= tc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        rel_d   = rel_q;
        tc_d    = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
            q_d     = '0;
        end else if (start) begin
            q_d   = load_val;
            rel_d = load_val;
            if (load_val == '0) begin
                // Zero-length run completes at once, but only from idle
                tc_d    = (state_q == ST_IDLE);
                state_d = ST_IDLE;
            end else begin
                state_d = ST_COUNT;
            end
        end else if (state_q == ST_COUNT && en) begin
            if (q_q > WIDTH'(1)) begin
                q_d = q_q - WIDTH'(1);
            end else begin
                // q==1 terminal count; q==0 cannot occur in COUNT
                tc_d = (q_q == WIDTH'(1));
                if (auto_rel && q_q == WIDTH'(1)) begin
                    q_d = rel_q;
                end else begin
                    q_d     = '0;
                    state_d = ST_IDLE;
                end
            end
        end
    end

    assign q    = q_q;
    assign tc   = tc_q;
    assign busy = (state_q == ST_COUNT);

endmodule

// File: tb/tb_down_counter.sv
// Directed test of down_counter against a per-cycle reference model.
module tb_down_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       en = 1'b0;
    logic       auto_rel = 1'b0;
    logic [6:0] load_val = '0;
    logic [6:0] q;
    logic       tc;
    logic       busy;

    int total = 0;
    int bad = 0;

    int m_q = 0;
    int m_rel = 0;
    int m_busy = 0;
    int m_tc = 0;

    down_counter dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .abort(abort),
        .en(en),
        .auto_rel(auto_rel),
        .load_val(load_val),
        .q(q),
        .tc(tc),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference: remaining count m_q, period m_rel, running flag m_busy
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_q = 0;
            m_rel = 0;
            m_busy = 0;
            m_tc = 0;
        end else begin
            m_tc = 0;
            if (abort) begin
                m_q = 0;
                m_busy = 0;
            end else if (start) begin
                m_rel = int'(load_val);
                m_q = m_rel;
                if (m_rel == 0) begin
                    m_tc = (m_busy == 0) ? 1 : 0;
                    m_busy = 0;
                end else begin
                    m_busy = 1;
                end
            end else if (m_busy == 1 && en) begin
                m_q = m_q - 1;
                if (m_q == 0) begin
                    m_tc = 1;
                    if (auto_rel) m_q = m_rel;
                    else m_busy = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        total++;
        if (int'(q) != m_q || int'(tc) != m_tc || int'(busy) != m_busy) begin
            bad++;
            $display("FAIL model t=%0t q=%0d tc=%0d busy=%0d want q=%0d tc=%0d busy=%0d",
                     $time, q, tc, busy, m_q, m_tc, m_busy);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic step(input logic s, input logic a, input logic e,
                        input logic ar, input int lv);
        start = s;
        abort = a;
        en = e;
        auto_rel = ar;
        load_val = 7'(lv);
        @(posedge clk);
        #3;
        start = 1'b0;
        abort = 1'b0;
    endtask

    int tcs;

    initial begin
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b1;
        step(0, 0, 1, 1, 9);
        step(0, 0, 1, 0, 0);
        chk("reset_q", int'(q), 0);
        chk("reset_tc", int'(tc), 0);
        chk("reset_busy", int'(busy), 0);

        // One-shot of 5
        step(1, 0, 1, 0, 5);
        chk("os_load", int'(q), 5);
        chk("os_busy", int'(busy), 1);
        for (int i = 4; i >= 1; i--) begin
            step(0, 0, 1, 0, 0);
            chk("os_q", int'(q), i);
            chk("os_tc_low", int'(tc), 0);
        end
        step(0, 0, 1, 0, 0);
        chk("os_end_q", int'(q), 0);
        chk("os_end_tc", int'(tc), 1);
        chk("os_end_busy", int'(busy), 0);
        step(0, 0, 1, 0, 0);
        chk("os_tc_pulse", int'(tc), 0);

        // Auto-reload period 3
        step(1, 0, 1, 1, 3);
        chk("ar_load", int'(q), 3);
        tcs = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 1, 1, 0);
            if (tc) begin
                tcs++;
                chk("ar_tc_q", int'(q), 3);
            end
        end
        chk("ar_tc_count", tcs, 3);
        chk("ar_last_q", int'(q), 2);
        step(0, 1, 0, 0, 0);
        chk("ar_abort_busy", int'(busy), 0);

        // Enable gaps
        step(1, 0, 0, 0, 4);
        step(0, 0, 1, 0, 0);
        chk("en_q3", int'(q), 3);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("en_hold", int'(q), 3);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("en_q1", int'(q), 1);
        chk("en_tc_early", int'(tc), 0);
        step(0, 0, 1, 0, 0);
        chk("en_tc", int'(tc), 1);
        chk("en_q0", int'(q), 0);

        // abort beats start mid-count
        step(1, 0, 1, 0, 12);
        repeat (3) step(0, 0, 1, 0, 0);
        chk("ab_q9", int'(q), 9);
        step(1, 1, 1, 0, 20);
        chk("ab_q", int'(q), 0);
        chk("ab_busy", int'(busy), 0);
        chk("ab_tc", int'(tc), 0);

        // start with zero load
        step(1, 0, 1, 0, 0);
        chk("z_tc", int'(tc), 1);
        chk("z_q", int'(q), 0);
        chk("z_busy", int'(busy), 0);
        step(0, 0, 1, 0, 0);
        chk("z_tc_pulse", int'(tc), 0);

        // restart in COUNT emits no tc
        step(1, 0, 1, 0, 6);
        step(0, 0, 1, 0, 0);
        step(1, 0, 1, 0, 2);
        chk("rs_q", int'(q), 2);
        chk("rs_tc", int'(tc), 0);
        step(0, 1, 0, 0, 0);

        // Max load, async reset at 64
        step(1, 0, 1, 0, 127);
        chk("mx_load", int'(q), 127);
        repeat (63) step(0, 0, 1, 0, 0);
        chk("mx_q64", int'(q), 64);
        #1 reset = 1'b0;
        #1;
        chk("ar_q", int'(q), 0);
        chk("ar_busy", int'(busy), 0);
        chk("ar_tc", int'(tc), 0);
        @(posedge clk);
        #3 reset = 1'b1;
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0);
        chk("post_q", int'(q), 0);
        chk("post_tc", int'(tc), 0);
        chk("post_busy", int'(busy), 0);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
